uart_mmio_host: RTL and testbench

//   Synthesizable register-bus initiator for uart_top: programs BAUD_DIV and CTRL after reset,

---
 rtl/uart_mmio_host.sv | 209 ++++++++++++++++++++
 tb/tb_uart_mmio_host.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_host.sv
// uart_mmio_host: register-bus initiator for uart_top.
// Programs BAUD_DIV and CTRL after reset. It then polls STATUS and moves bytes
// between the s_tx/m_rx valid-ready streams and the TX_DATA/RX_DATA registers.
// Bus outputs are registered on entry to a state. Each state therefore owns
// exactly the bus cycle during which it is current.
module uart_mmio_host #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter logic [31:0] CTRL_INIT   = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_tx_data,
    input  logic        s_tx_valid,
    output logic        s_tx_ready,
    output logic [7:0]  m_rx_data,
    output logic        m_rx_valid,
    input  logic        m_rx_ready,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_ctrl,
    input  logic        cfg_load,
    output logic        init_done,
    output logic [3:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        wr_en,
    output logic        rd_en
);

    localparam logic [15:0] DIVISOR = 16'(CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE));

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_BAUD_DIV = 4'd2;
    localparam logic [3:0] ADDR_TX_DATA  = 4'd3;
    localparam logic [3:0] ADDR_RX_DATA  = 4'd4;

    localparam logic [2:0] ST_CFG_DIV  = 3'd0;
    localparam logic [2:0] ST_CFG_CTRL = 3'd1;
    localparam logic [2:0] ST_POLL     = 3'd2;
    localparam logic [2:0] ST_DECIDE   = 3'd3;
    localparam logic [2:0] ST_WR_TX    = 3'd4;
    localparam logic [2:0] ST_RD_RX    = 3'd5;
    localparam logic [2:0] ST_CAP_RX   = 3'd6;

    logic [2:0]  r_state;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_wr_en;
    logic        r_rd_en;
    logic        r_tx_ready;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_init_done;
    logic        r_cfg_pend;
    logic [15:0] r_div;
    logic [31:0] r_ctrl;
    logic        r_last_tx;   // 1: TX was served last, so RX wins the next tie

    logic [2:0]  w_next;
    logic        w_redirect;
    logic        w_tx_ok;
    logic        w_rx_ok;
    logic        w_rdata_unused;

    // STATUS bits are meaningful only in DECIDE, when rdata holds the STATUS read.
    assign w_tx_ok        = s_tx_valid & ~rdata[1];
    assign w_rx_ok        = ~rdata[2] & ~r_rx_valid;
    assign w_rdata_unused = ^rdata[31:8];

    // Next-state selection, including redirection of POLL to reconfiguration.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_next     = r_state;
        w_redirect = 1'b0;
        case (r_state)
            // After reset the write has not been issued yet, so hold one cycle.
            ST_CFG_DIV:  w_next = r_wr_en ? ST_CFG_CTRL : ST_CFG_DIV;
            ST_CFG_CTRL: w_next = ST_POLL;
            ST_POLL:     w_next = ST_DECIDE;
            ST_DECIDE: begin
                if (w_tx_ok && w_rx_ok) begin
                    w_next = r_last_tx ? ST_RD_RX : ST_WR_TX;
                end else if (w_tx_ok) begin
                    w_next = ST_WR_TX;
                end else if (w_rx_ok) begin
                    w_next = ST_RD_RX;
                end else begin
                    w_next = ST_POLL;
                end
            end
            ST_WR_TX:  w_next = ST_POLL;
            ST_RD_RX:  w_next = ST_CAP_RX;
            ST_CAP_RX: w_next = ST_POLL;
            default:   w_next = ST_CFG_DIV;
        endcase
        // POLL's bus op is issued on entry. A pending reconfiguration must
        // therefore be diverted here, before the STATUS read goes out.
        if (w_next == ST_POLL && r_cfg_pend) begin
            w_redirect = 1'b1;
            w_next     = ST_CFG_DIV;
        end
    end

    // State register and the bus outputs belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CFG_DIV;
            r_addr     <= 4'd0;
            r_wdata    <= 32'd0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_next;
            r_wr_en    <= (w_next == ST_CFG_DIV) || (w_next == ST_CFG_CTRL) || (w_next == ST_WR_TX);
            r_rd_en    <= (w_next == ST_POLL) || (w_next == ST_RD_RX);
            r_tx_ready <= (w_next == ST_WR_TX);
            case (w_next)
                ST_CFG_DIV: begin
                    r_addr  <= ADDR_BAUD_DIV;
                    r_wdata <= {16'd0, r_div};
                end
                ST_CFG_CTRL: begin
                    r_addr  <= ADDR_CTRL;
                    r_wdata <= r_ctrl;
                end
                ST_POLL: begin
                    r_addr  <= ADDR_STATUS;
                    r_wdata <= 32'd0;
                end
                ST_WR_TX: begin
                    r_addr  <= ADDR_TX_DATA;
                    r_wdata <= {24'd0, s_tx_data};
                end
                ST_RD_RX: begin
                    r_addr  <= ADDR_RX_DATA;
                    r_wdata <= 32'd0;
                end
                default: begin
                    r_addr  <= 4'd0;
                    r_wdata <= 32'd0;
                end
            endcase
        end
    end

    // Configuration values and the pending flag. A load wins over a
    // simultaneous service, so the latest values always reach the UART.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_pend <= 1'b0;
            r_div      <= DIVISOR;
            r_ctrl     <= CTRL_INIT;
        end else if (cfg_load) begin
            r_cfg_pend <= 1'b1;
            r_div      <= cfg_div;
            r_ctrl     <= {24'd0, cfg_ctrl};
        end else if (w_redirect) begin
            r_cfg_pend <= 1'b0;
        end
    end

    // init_done rises once the CTRL write of the first configuration has been issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else if (r_state == ST_CFG_CTRL) begin
            r_init_done <= 1'b1;
        end
    end

    // Round-robin memory. After reset it points at RX, so TX wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_tx <= 1'b0;
        end else if (r_state == ST_DECIDE && w_next == ST_WR_TX) begin
            r_last_tx <= 1'b1;
        end else if (r_state == ST_DECIDE && w_next == ST_RD_RX) begin
            r_last_tx <= 1'b0;
        end
    end

    // One-byte RX holding register. It fills from the RX_DATA read and
    // empties on the consumer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
        end else if (r_state == ST_CAP_RX) begin
            r_rx_data  <= rdata[7:0];
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && m_rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign wr_en      = r_wr_en;
    assign rd_en      = r_rd_en;
    assign s_tx_ready = r_tx_ready;
    assign m_rx_data  = r_rx_data;
    assign m_rx_valid = r_rx_valid;
    assign init_done  = r_init_done;

endmodule

// File: tb/tb_uart_mmio_host.sv
// tb_uart_mmio_host: directed and randomized bench for uart_mmio_host.
// A behavioural uart_top register model sits on the bus. Expected traffic
// comes from the stream contents pushed by the bench.
module tb_uart_mmio_host;

    localparam int DIV_DEF = 50000000 / (115200 * 16);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tx_data = 8'd0;
    logic        s_tx_valid = 1'b0;
    logic        s_tx_ready;
    logic [7:0]  m_rx_data;
    logic        m_rx_valid;
    logic        m_rx_ready = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic [7:0]  cfg_ctrl = 8'd0;
    logic        cfg_load = 1'b0;
    logic        init_done;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;
    logic        wr_en;
    logic        rd_en;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        int          cyc;
        logic        rdy;
    } wr_t;

    wr_t        wlog[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_written[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] rx_got[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         ops[$];
    int         rd4_cnt = 0;
    int         cyc = 0;
    int         tx_hs = 0;
    int         bus_viol = 0;
    int         total = 0;
    int         bad = 0;
    logic       tx_full = 1'b0;
    logic       tx_rand = 1'b0;
    logic       rx_rand = 1'b0;
    logic [31:0] ctrl_reg = 32'd0;

    uart_mmio_host dut (
        .clk(clk), .rst(rst),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .cfg_div(cfg_div), .cfg_ctrl(cfg_ctrl), .cfg_load(cfg_load),
        .init_done(init_done), .addr(addr), .wdata(wdata), .rdata(rdata),
        .wr_en(wr_en), .rd_en(rd_en)
    );

    always #5 clk = ~clk;

    // uart_top register model: registered read data, TX log, optional loopback.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (wr_en && rd_en) bus_viol++;
        if (rd_en) begin
            if (addr == 4'd1) begin
                rdata <= {29'd0, (rx_fifo.size() == 0), tx_full, 1'b0};
            end else if (addr == 4'd4) begin
                rd4_cnt++;
                ops.push_back(4);
                if (rx_fifo.size() > 0) rdata <= {24'd0, rx_fifo.pop_front()};
                else rdata <= 32'd0;
            end else begin
                rdata <= 32'd0;
            end
        end
        if (wr_en) begin
            wlog.push_back('{a: addr, d: wdata, cyc: cyc, rdy: s_tx_ready});
            if (addr == 4'd0) ctrl_reg <= wdata;
            if (addr == 4'd3) begin
                tx_written.push_back(wdata[7:0]);
                ops.push_back(3);
                if (ctrl_reg[3]) rx_fifo.push_back(wdata[7:0]);
            end
        end
    end

    // Stream source and random knobs, driven away from the active edge.
    initial forever begin
        @(negedge clk);
        if (tx_rand) tx_full = ($urandom_range(0, 3) == 0);
        if (rx_rand) m_rx_ready = 1'($urandom_range(0, 1));
        if (tx_q.size() > 0) begin
            s_tx_valid = 1'b1;
            s_tx_data  = tx_q[0];
        end else begin
            s_tx_valid = 1'b0;
            s_tx_data  = 8'd0;
        end
    end

    // Handshake observers for both streams.
    initial forever begin
        @(posedge clk);
        if (s_tx_valid && s_tx_ready) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            tx_hs++;
        end
        if (!rst && m_rx_valid && m_rx_ready) rx_got.push_back(m_rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int count_tx(input int from);
        int n = 0;
        for (int i = from; i < wlog.size(); i++) if (wlog[i].a == 4'd3) n++;
        return n;
    endfunction

    function automatic int first_tx(input int from);
        for (int i = from; i < wlog.size(); i++) if (wlog[i].a == 4'd3) return i;
        return -1;
    endfunction

    task automatic wait_txq_empty(input int budget);
        for (int i = 0; i < budget && tx_q.size() > 0; i++) @(negedge clk);
    endtask

    task automatic load_cfg(input logic [15:0] d, input logic [7:0] c);
        cfg_div  = d;
        cfg_ctrl = c;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    initial begin
        int base, idx, h0, r0, g0, w0, o0, same, found;
        logic [7:0] b;

        // Reset state and initial configuration sequence.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({wr_en, rd_en, s_tx_ready, m_rx_valid, init_done}), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_rxdata", 32'(m_rx_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20 && wlog.size() < 2; i++) @(negedge clk);
        check("init_cnt", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check("init_div_addr", 32'(wlog[0].a), 32'd2);
            check("init_div_data", wlog[0].d, 32'(DIV_DEF));
            check("init_ctrl_addr", 32'(wlog[1].a), 32'd0);
            check("init_ctrl_data", wlog[1].d, 32'd1);
            check("init_consecutive", 32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
        end
        check("init_done", 32'(init_done), 32'd1);

        // Single TX byte with TX FIFO not full.
        base = wlog.size();
        h0 = tx_hs;
        tx_q.push_back(8'h55);
        wait_txq_empty(50);
        repeat (4) @(negedge clk);
        check("tx55_count", 32'(count_tx(base)), 32'd1);
        idx = first_tx(base);
        if (idx >= 0) begin
            check("tx55_data", wlog[idx].d, 32'h55);
            check("tx55_ready", 32'(wlog[idx].rdy), 32'd1);
        end
        check("tx55_hs", 32'(tx_hs - h0), 32'd1);

        // TX FIFO full: the byte must wait.
        tx_full = 1'b1;
        base = wlog.size();
        h0 = tx_hs;
        tx_q.push_back(8'hA7);
        repeat (40) @(negedge clk);
        check("txfull_nowrite", 32'(count_tx(base)), 32'd0);
        check("txfull_hs", 32'(tx_hs - h0), 32'd0);
        tx_full = 1'b0;
        wait_txq_empty(50);
        repeat (4) @(negedge clk);
        check("txfull_release", 32'(count_tx(base)), 32'd1);
        idx = first_tx(base);
        if (idx >= 0) check("txfull_data", wlog[idx].d, 32'hA7);

        // RX with consumer stalled: only one byte is buffered.
        m_rx_ready = 1'b0;
        r0 = rd4_cnt;
        rx_fifo.push_back(8'h48);
        rx_fifo.push_back(8'h45);
        repeat (40) @(negedge clk);
        check("rx_hold_valid", 32'(m_rx_valid), 32'd1);
        check("rx_hold_data", 32'(m_rx_data), 32'h48);
        check("rx_hold_reads", 32'(rd4_cnt - r0), 32'd1);
        check("rx_hold_fifo", 32'(rx_fifo.size()), 32'd1);
        g0 = rx_got.size();
        m_rx_ready = 1'b1;
        for (int i = 0; i < 60 && rx_got.size() < g0 + 2; i++) @(negedge clk);
        m_rx_ready = 1'b0;
        check("rx_got_cnt", 32'(rx_got.size() - g0), 32'd2);
        if (rx_got.size() >= g0 + 2) begin
            check("rx_got0", 32'(rx_got[g0]), 32'h48);
            check("rx_got1", 32'(rx_got[g0+1]), 32'h45);
        end
        check("rx_reads", 32'(rd4_cnt - r0), 32'd2);

        // Both directions ready: data ops must alternate.
        m_rx_ready = 1'b1;
        o0 = ops.size();
        for (int i = 0; i < 4; i++) begin
            rx_fifo.push_back(8'(8'h60 + i));
            tx_q.push_back(8'(8'h70 + i));
        end
        for (int i = 0; i < 200 && (tx_q.size() > 0 || rx_fifo.size() > 0 || m_rx_valid); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("alt_ops", 32'(ops.size() - o0), 32'd8);
        same = 0;
        for (int i = o0 + 1; i < ops.size(); i++) if (ops[i] == ops[i-1]) same++;
        check("alt_same_adj", 32'(same), 32'd0);

        // Randomized traffic: both streams must arrive complete and in order.
        w0 = tx_written.size();
        g0 = rx_got.size();
        exp_tx.delete();
        exp_rx.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_tx.push_back(b);
            tx_q.push_back(b);
            b = 8'($urandom_range(0, 255));
            exp_rx.push_back(b);
            rx_fifo.push_back(b);
        end
        tx_rand = 1'b1;
        rx_rand = 1'b1;
        for (int i = 0; i < 4000 && (tx_written.size() - w0 < 24 || rx_got.size() - g0 < 24); i++) @(negedge clk);
        tx_rand = 1'b0;
        rx_rand = 1'b0;
        tx_full = 1'b0;
        m_rx_ready = 1'b1;
        check("rand_tx_cnt", 32'(tx_written.size() - w0), 32'd24);
        check("rand_rx_cnt", 32'(rx_got.size() - g0), 32'd24);
        for (int i = 0; i < 24; i++) begin
            if (w0 + i < tx_written.size()) check("rand_tx_byte", 32'(tx_written[w0+i]), 32'(exp_tx[i]));
            if (g0 + i < rx_got.size()) check("rand_rx_byte", 32'(rx_got[g0+i]), 32'(exp_rx[i]));
        end

        // Loopback run: bytes written to TX return in order.
        load_cfg(16'(DIV_DEF), 8'h09);
        for (int i = 0; i < 40 && ctrl_reg != 32'h9; i++) @(negedge clk);
        check("lb_ctrl", ctrl_reg, 32'h9);
        g0 = rx_got.size();
        exp_rx.delete();
        exp_rx.push_back(8'h4C);
        exp_rx.push_back(8'h4F);
        exp_rx.push_back(8'h4F);
        exp_rx.push_back(8'h50);
        foreach (exp_rx[i]) tx_q.push_back(exp_rx[i]);
        for (int i = 0; i < 300 && rx_got.size() < g0 + 4; i++) @(negedge clk);
        check("lb_cnt", 32'(rx_got.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (g0 + i < rx_got.size()) check("lb_byte", 32'(rx_got[g0+i]), 32'(exp_rx[i]));
        load_cfg(16'(DIV_DEF), 8'h01);
        for (int i = 0; i < 40 && ctrl_reg != 32'h1; i++) @(negedge clk);
        repeat (10) @(negedge clk);

        // Reconfiguration mid-transfer.
        base = wlog.size();
        w0 = tx_written.size();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'(8'h10 + i));
        repeat (6) @(negedge clk);
        load_cfg(16'd13, 8'h01);
        wait_txq_empty(200);
        repeat (6) @(negedge clk);
        found = 0;
        for (int i = base; i + 1 < wlog.size(); i++)
            if (wlog[i].a == 4'd2 && wlog[i].d == 32'd13 && wlog[i+1].a == 4'd0 && wlog[i+1].d == 32'd1) found = 1;
        check("cfg_reload_seq", 32'(found), 32'd1);
        check("cfg_tx_cnt", 32'(tx_written.size() - w0), 32'd6);
        for (int i = 0; i < 6; i++)
            if (w0 + i < tx_written.size()) check("cfg_tx_byte", 32'(tx_written[w0+i]), 32'(8'h10 + i));

        // Reset pulse during a TX_DATA write.
        for (int i = 0; i < 3; i++) tx_q.push_back(8'(8'hC0 + i));
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (wr_en && addr == 4'd3) found = 1;
        end
        check("saw_wrtx", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", 32'({wr_en, rd_en, s_tx_ready, init_done}), 32'd0);
        rst = 1'b0;
        base = wlog.size();
        for (int i = 0; i < 20 && wlog.size() < base + 2; i++) @(negedge clk);
        check("reinit_cnt", 32'(wlog.size() - base), 32'd2);
        if (wlog.size() >= base + 2) begin
            check("reinit_div", wlog[base].d, 32'(DIV_DEF));
            check("reinit_div_addr", 32'(wlog[base].a), 32'd2);
            check("reinit_ctrl", wlog[base+1].d, 32'd1);
            check("reinit_ctrl_addr", 32'(wlog[base+1].a), 32'd0);
        end
        wait_txq_empty(200);
        check("bus_rule", 32'(bus_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
